// File: rtl/cosim_commit_tracker.sv
// Commit-record generator for the co-simulation checker: carries the MEM-stage store
// alongside the instruction to WB, emits one registered record per retirement, and
// tracks retired-instruction count, pending async traps and a pipeline-hang watchdog.
module cosim_commit_tracker #(
  parameter logic [63:0] MMIO_BASE       = 64'h0000_0000_1000_0000,
  parameter logic [63:0] MMIO_SIZE       = 64'h0000_0000_0000_1000,
  parameter int          WATCHDOG_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_valid,
  input  logic        mem_store,
  input  logic [63:0] mem_addr,
  input  logic [1:0]  mem_size,
  input  logic [63:0] mem_wdata,
  input  logic        wb_stall,
  input  logic        wb_flush,
  input  logic        wb_valid,
  input  logic [63:0] wb_pc,
  input  logic [31:0] wb_inst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_wdata,
  input  logic        trap_valid,
  input  logic [63:0] trap_cause,
  output logic        cosim_valid,
  output logic [63:0] cosim_pc,
  output logic [31:0] cosim_inst,
  output logic        cosim_we,
  output logic [4:0]  cosim_rd,
  output logic [63:0] cosim_wdate,
  output logic        cosim_mmio_store,
  output logic [63:0] cosim_mmio_len,
  output logic [63:0] cosim_mmio_val,
  output logic [63:0] cosim_mmio_addr,
  output logic        cosim_interrupt,
  output logic [63:0] cosim_cause,
  output logic [63:0] retire_count,
  output logic        trap_overrun,
  output logic        hang
);

  localparam int WD_W = (WATCHDOG_CYCLES > 2) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_CYCLES - 1);

  // Store slot shadowing the MEM/WB pipeline register
  logic        st_valid;
  logic [63:0] st_addr;
  logic [1:0]  st_size;
  logic [63:0] st_wdata;

  logic        trap_pending;
  logic [63:0] trap_cause_q;

  logic [WD_W-1:0] wd_cnt;
  logic            wd_armed;

  logic        mmio_hit;
  logic [63:0] mmio_len;
  logic [63:0] mmio_mask;
  logic        retire_we;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    mmio_mask = '1;
    case (st_size)
      2'd0:    mmio_mask = 64'h0000_0000_0000_00FF;
      2'd1:    mmio_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    mmio_mask = 64'h0000_0000_FFFF_FFFF;
      default: mmio_mask = '1;
    endcase
    // Offset compare avoids overflow of BASE+SIZE at the top of the address space.
    mmio_hit  = st_valid && ((st_addr - MMIO_BASE) < MMIO_SIZE);
    mmio_len  = 64'd1 << st_size;
    retire_we = wb_we && (wb_rd != 5'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_valid         <= 1'b0;
      st_addr          <= '0;
      st_size          <= '0;
      st_wdata         <= '0;
      trap_pending     <= 1'b0;
      trap_cause_q     <= '0;
      wd_cnt           <= '0;
      wd_armed         <= 1'b0;
      cosim_valid      <= 1'b0;
      cosim_pc         <= '0;
      cosim_inst       <= '0;
      cosim_we         <= 1'b0;
      cosim_rd         <= '0;
      cosim_wdate      <= '0;
      cosim_mmio_store <= 1'b0;
      cosim_mmio_len   <= '0;
      cosim_mmio_val   <= '0;
      cosim_mmio_addr  <= '0;
      cosim_interrupt  <= 1'b0;
      cosim_cause      <= '0;
      retire_count     <= '0;
      trap_overrun     <= 1'b0;
      hang             <= 1'b0;
    end else begin
      if (wb_flush) begin
        st_valid <= 1'b0;
        st_addr  <= '0;
        st_size  <= '0;
        st_wdata <= '0;
      end else if (!wb_stall) begin
        st_valid <= mem_valid & mem_store;
        st_addr  <= mem_addr;
        st_size  <= mem_size;
        st_wdata <= mem_wdata;
      end

      cosim_valid      <= wb_valid;
      cosim_pc         <= wb_valid ? wb_pc : '0;
      cosim_inst       <= wb_valid ? wb_inst : '0;
      cosim_rd         <= wb_valid ? wb_rd : '0;
      cosim_we         <= wb_valid && retire_we;
      cosim_wdate      <= (wb_valid && retire_we) ? wb_wdata : '0;
      cosim_mmio_store <= wb_valid && mmio_hit;
      cosim_mmio_len   <= (wb_valid && mmio_hit) ? mmio_len : '0;
      cosim_mmio_val   <= (wb_valid && mmio_hit) ? (st_wdata & mmio_mask) : '0;
      cosim_mmio_addr  <= (wb_valid && mmio_hit) ? st_addr : '0;
      cosim_interrupt  <= wb_valid && trap_pending;
      cosim_cause      <= (wb_valid && trap_pending) ? trap_cause_q : '0;

      // A trap arriving with a retirement belongs after that (older) instruction.
      if (wb_valid && trap_pending) begin
        trap_pending <= trap_valid;
        if (trap_valid) trap_cause_q <= trap_cause;
      end else if (trap_valid) begin
        if (trap_pending) trap_overrun <= 1'b1;
        trap_pending <= 1'b1;
        trap_cause_q <= trap_cause;
      end

      if (wb_valid) retire_count <= retire_count + 64'd1;

      if (wb_valid) begin
        wd_cnt   <= '0;
        wd_armed <= 1'b1;
      end else if (wd_cnt != WD_LIMIT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_armed && (wd_cnt == WD_LIMIT)) hang <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cosim_commit_tracker.sv
// Directed bench for cosim_commit_tracker: hand-computed commit records, MMIO window
// edges, trap ordering/overrun, retire counter, watchdog and reset behaviour.
module tb_cosim_commit_tracker;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_valid, mem_store;
  logic [63:0] mem_addr;
  logic [1:0]  mem_size;
  logic [63:0] mem_wdata;
  logic        wb_stall, wb_flush, wb_valid;
  logic [63:0] wb_pc;
  logic [31:0] wb_inst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_wdata;
  logic        trap_valid;
  logic [63:0] trap_cause;
  logic        cosim_valid;
  logic [63:0] cosim_pc;
  logic [31:0] cosim_inst;
  logic        cosim_we;
  logic [4:0]  cosim_rd;
  logic [63:0] cosim_wdate;
  logic        cosim_mmio_store;
  logic [63:0] cosim_mmio_len, cosim_mmio_val, cosim_mmio_addr;
  logic        cosim_interrupt;
  logic [63:0] cosim_cause;
  logic [63:0] retire_count;
  logic        trap_overrun, hang;

  int checks = 0;
  int errors = 0;
  longint unsigned exp_count = 0;

  always #5 clk = ~clk;

  cosim_commit_tracker dut (
    .clk(clk), .rstn(rstn),
    .mem_valid(mem_valid), .mem_store(mem_store), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_wdata(mem_wdata),
    .wb_stall(wb_stall), .wb_flush(wb_flush), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .trap_valid(trap_valid), .trap_cause(trap_cause),
    .cosim_valid(cosim_valid), .cosim_pc(cosim_pc), .cosim_inst(cosim_inst),
    .cosim_we(cosim_we), .cosim_rd(cosim_rd), .cosim_wdate(cosim_wdate),
    .cosim_mmio_store(cosim_mmio_store), .cosim_mmio_len(cosim_mmio_len),
    .cosim_mmio_val(cosim_mmio_val), .cosim_mmio_addr(cosim_mmio_addr),
    .cosim_interrupt(cosim_interrupt), .cosim_cause(cosim_cause),
    .retire_count(retire_count), .trap_overrun(trap_overrun), .hang(hang)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_valid = 0; mem_store = 0; mem_addr = '0; mem_size = '0; mem_wdata = '0;
    wb_stall = 0; wb_flush = 0; wb_valid = 0;
    wb_pc = '0; wb_inst = '0; wb_we = 0; wb_rd = '0; wb_wdata = '0;
    trap_valid = 0; trap_cause = '0;
  endtask

  task automatic drive_store(input logic [63:0] addr, input logic [1:0] size,
                             input logic [63:0] data);
    mem_valid = 1; mem_store = 1; mem_addr = addr; mem_size = size; mem_wdata = data;
  endtask

  task automatic retire(input logic [63:0] pc, input logic [31:0] inst, input logic we,
                        input logic [4:0] rd, input logic [63:0] wdata);
    wb_valid = 1; wb_pc = pc; wb_inst = inst; wb_we = we; wb_rd = rd; wb_wdata = wdata;
    tick();
    exp_count++;
    clear_inputs();
  endtask

  task automatic store_then_retire(input string tag, input logic [63:0] addr,
                                   input logic [1:0] size, input logic [63:0] data,
                                   input logic exp_mmio, input logic [63:0] exp_len,
                                   input logic [63:0] exp_val);
    drive_store(addr, size, data);
    tick();
    clear_inputs();
    retire(64'h8000_0100, 32'h00b5_2023, 1'b0, 5'd0, 64'd0);
    check({tag, "_store"}, 64'(cosim_mmio_store), 64'(exp_mmio));
    check({tag, "_len"}, cosim_mmio_len, exp_len);
    check({tag, "_val"}, cosim_mmio_val, exp_val);
    check({tag, "_addr"}, cosim_mmio_addr, exp_mmio ? addr : 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(cosim_valid), 64'd0);
    check({tag, "_pc"}, cosim_pc, 64'd0);
    check({tag, "_mmio"}, 64'(cosim_mmio_store), 64'd0);
    check({tag, "_int"}, 64'(cosim_interrupt), 64'd0);
    check({tag, "_count"}, retire_count, 64'd0);
    check({tag, "_overrun"}, 64'(trap_overrun), 64'd0);
    check({tag, "_hang"}, 64'(hang), 64'd0);
  endtask

  initial begin
    clear_inputs();
    rstn = 0;
    tick();
    tick();
    check_all_zero("reset");
    rstn = 1;

    // Plain commit, then an idle cycle
    retire(64'h8000_0000, 32'h0050_0093, 1'b1, 5'd1, 64'd5);
    check("plain_valid", 64'(cosim_valid), 64'd1);
    check("plain_pc", cosim_pc, 64'h8000_0000);
    check("plain_inst", 64'(cosim_inst), 64'h0050_0093);
    check("plain_we", 64'(cosim_we), 64'd1);
    check("plain_rd", 64'(cosim_rd), 64'd1);
    check("plain_wdata", cosim_wdate, 64'd5);
    check("plain_int", 64'(cosim_interrupt), 64'd0);
    tick();
    check("idle_valid", 64'(cosim_valid), 64'd0);
    check("idle_pc", cosim_pc, 64'd0);

    // Write to x0 is suppressed
    retire(64'h8000_0004, 32'h0000_0013, 1'b1, 5'd0, 64'h1234);
    check("x0_we", 64'(cosim_we), 64'd0);
    check("x0_wdata", cosim_wdate, 64'd0);

    // Store held through a 3-cycle stall while MEM presents a different store
    drive_store(64'h1000_0008, 2'd3, 64'h1122_3344_5566_7788);
    tick();
    drive_store(64'h8000_0000, 2'd0, 64'hFF);
    wb_stall = 1;
    repeat (3) tick();
    clear_inputs();
    retire(64'h8000_0008, 32'h00b5_3423, 1'b0, 5'd0, 64'd0);
    check("stall_store", 64'(cosim_mmio_store), 64'd1);
    check("stall_len", cosim_mmio_len, 64'd8);
    check("stall_val", cosim_mmio_val, 64'h1122_3344_5566_7788);
    check("stall_addr", cosim_mmio_addr, 64'h1000_0008);

    // MMIO window and size masking
    store_then_retire("mmio_b", 64'h1000_0000, 2'd0, 64'hFFFF_FF41, 1'b1, 64'd1, 64'h41);
    store_then_retire("ram_b", 64'h8000_1000, 2'd0, 64'hFFFF_FF41, 1'b0, 64'd0, 64'd0);
    store_then_retire("top_h", 64'h1000_0FFF, 2'd1, 64'hABCD_1234, 1'b1, 64'd2, 64'h1234);
    store_then_retire("end_w", 64'h1000_1000, 2'd2, 64'hDEAD_BEEF, 1'b0, 64'd0, 64'd0);
    store_then_retire("below", 64'h0FFF_FFFF, 2'd0, 64'h55, 1'b0, 64'd0, 64'd0);
    store_then_retire("word", 64'h1000_0010, 2'd2, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 64'd4,
                      64'hCAFE_F00D);

    // Flush discards the store moving from MEM into WB
    drive_store(64'h1000_0000, 2'd0, 64'h41);
    wb_flush = 1;
    wb_stall = 1;
    tick();
    clear_inputs();
    retire(64'h8000_0200, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
    check("flush_mmio", 64'(cosim_mmio_store), 64'd0);

    // Trap arriving with a retire: that record is older and carries no interrupt
    trap_valid = 1; trap_cause = 64'h8000_0000_0000_0007;
    retire(64'h8000_0300, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
    check("trap_same_int", 64'(cosim_interrupt), 64'd0);
    check("trap_same_cause", cosim_cause, 64'd0);
    tick();
    check("trap_idle_int", 64'(cosim_interrupt), 64'd0);
    // Handler's first commit consumes it while a new trap arrives: no overrun
    trap_valid = 1; trap_cause = 64'h8000_0000_0000_0003;
    retire(64'h8000_0400, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
    check("trap_emit_int", 64'(cosim_interrupt), 64'd1);
    check("trap_emit_cause", cosim_cause, 64'h8000_0000_0000_0007);
    check("trap_no_overrun", 64'(trap_overrun), 64'd0);
    retire(64'h8000_0404, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
    check("trap2_int", 64'(cosim_interrupt), 64'd1);
    check("trap2_cause", cosim_cause, 64'h8000_0000_0000_0003);
    retire(64'h8000_0408, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
    check("trap_cleared", 64'(cosim_interrupt), 64'd0);

    // Two traps before any retire: overrun, later cause wins
    trap_valid = 1; trap_cause = 64'h8000_0000_0000_0003;
    tick();
    trap_cause = 64'h8000_0000_0000_000B;
    tick();
    clear_inputs();
    check("overrun", 64'(trap_overrun), 64'd1);
    retire(64'h8000_0500, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
    check("overrun_int", 64'(cosim_interrupt), 64'd1);
    check("overrun_cause", cosim_cause, 64'h8000_0000_0000_000B);
    check("count_mid", retire_count, 64'(exp_count));

    // Reset with a pending trap and captured store: both discarded
    trap_valid = 1; trap_cause = 64'h8000_0000_0000_0007;
    drive_store(64'h1000_0000, 2'd0, 64'h41);
    tick();
    clear_inputs();
    rstn = 0;
    tick();
    check_all_zero("midreset");
    rstn = 1;
    exp_count = 0;
    retire(64'h8000_0000, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
    check("post_rst_int", 64'(cosim_interrupt), 64'd0);
    check("post_rst_mmio", 64'(cosim_mmio_store), 64'd0);
    for (int i = 1; i < 10; i++)
      retire(64'h8000_0000 + 64'(4 * i), 32'h0000_0013, 1'b0, 5'd0, 64'd0);
    check("count_10", retire_count, 64'd10);

    // Watchdog: hang asserts on the 4096th idle edge after the last commit
    repeat (4095) tick();
    check("hang_not_yet", 64'(hang), 64'd0);
    tick();
    check("hang_set", 64'(hang), 64'd1);
    repeat (5) tick();
    check("hang_sticky", 64'(hang), 64'd1);

    rstn = 0;
    tick();
    check_all_zero("final_reset");
    rstn = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cosim_commit_tracker.md
Name: cosim_commit_tracker

Overview:
- Sits between the pipeline's MEM/WB boundary and the co-simulation checker.
- Captures MEM-stage store info and carries it alongside the instruction to writeback.
- Emits one registered commit record per retired instruction: pc, inst, rd write, MMIO store and pending async trap cause.
- Also counts retired instructions and flags a stalled pipeline via a watchdog.

Parameters:
- MMIO_BASE, 64'h0000_0000_1000_0000, first byte address treated as MMIO.
- MMIO_SIZE, 64'h0000_0000_0000_1000, MMIO window length in bytes; addr in [BASE, BASE+SIZE) is MMIO.
- WATCHDOG_CYCLES, 4096, cycles without a commit (after the first commit) before hang is flagged.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- mem_valid  in  1  MEM stage holds a real instruction
- mem_store  in  1  MEM instruction is a store
- mem_addr  in  64  store byte address
- mem_size  in  2  store size: 0=1B, 1=2B, 2=4B, 3=8B
- mem_wdata  in  64  store data, LSB-aligned
- wb_stall  in  1  MEM/WB register holds
- wb_flush  in  1  MEM/WB register loads a bubble
- wb_valid  in  1  WB instruction retires this cycle
- wb_pc  in  64  retiring pc
- wb_inst  in  32  retiring instruction
- wb_we  in  1  retiring instruction writes rd
- wb_rd  in  5  destination register
- wb_wdata  in  64  writeback value
- trap_valid  in  1  async interrupt taken this cycle
- trap_cause  in  64  mcause value of that interrupt
- cosim_valid  out  1  commit record valid
- cosim_pc  out  64
- cosim_inst  out  32
- cosim_we  out  1
- cosim_rd  out  5
- cosim_wdate  out  64
- cosim_mmio_store  out  1
- cosim_mmio_len  out  64
- cosim_mmio_val  out  64
- cosim_mmio_addr  out  64
- cosim_interrupt  out  1
- cosim_cause  out  64
- retire_count  out  64  instructions retired since reset
- trap_overrun  out  1  sticky: second trap arrived while one was pending
- hang  out  1  sticky watchdog expiry

Behaviour:
- Reset (rstn=0 at posedge): every output is 0; internal store slot, pending trap, watchdog counter and armed flag are cleared.
- Store slot (mirrors MEM/WB), updated each posedge:
  - wb_flush=1 -> slot cleared (flush wins over stall).
  - else wb_stall=1 -> slot holds.
  - else slot <= {mem_valid & mem_store, mem_addr, mem_size, mem_wdata}.
- Commit output: registered, 1-cycle latency from wb_valid. All cosim_* outputs are rewritten every cycle; cosim_valid=0 on non-retire cycles.
- On wb_valid=1, next cycle:
  - cosim_valid=1; pc/inst/rd copied.
  - cosim_we = wb_we & (wb_rd!=0); cosim_wdate = cosim_we ? wb_wdata : 0.
- MMIO store: cosim_mmio_store=1 only when wb_valid=1, the slot holds a store, and its addr is in the MMIO window.
  - len = 1<<size.
  - val = data masked to len bytes.
  - addr is copied unchanged.
  - Otherwise len/val/addr are 0.
- Window compare: 64-bit unsigned, computed as (addr-MMIO_BASE) < MMIO_SIZE, so no overflow at the top of the address space.
- Trap: trap_valid sets the pending flag and latches the cause.
  - A commit in the same cycle is the older instruction: it emits with cosim_interrupt=0.
  - The pending trap emits with the next wb_valid, i.e. cosim_interrupt=1 alongside the handler's first commit, then pending clears.
  - trap_valid while pending is already set: the cause is overwritten and trap_overrun is set (sticky).
  - trap_valid in the same cycle a pending trap is consumed: the old trap emits and the new one becomes pending, with no overrun.
- retire_count increments on each wb_valid and wraps at 2^64.
- Watchdog: armed by the first wb_valid.
  - Counter resets to 0 on each wb_valid, otherwise increments, saturating.
  - hang is set when the counter reaches WATCHDOG_CYCLES-1 while armed.
- Reset mid-operation: pending trap, slot and outputs are discarded; no partial record is emitted.

Test Plan:
- Plain commit: wb_valid with pc=0x80000000, inst=0x00500093, we=1, rd=1, wdata=5 -> next cycle cosim_valid=1 and the same fields; following idle cycle cosim_valid=0.
- x0 write and stall:
  - wb_we=1, rd=0, wdata=0x1234 -> cosim_we=0, wdate=0.
  - A store captured, then wb_stall held 3 cycles -> store data survives and emits at retire.
- MMIO store: mem addr=0x10000000, size=0, wdata=0xFFFF_FF41 -> at retire mmio_store=1, len=1, val=0x41, addr=0x10000000. Same store at 0x80001000 -> mmio_store=0.
- Window edges: addr=0x10000FFF -> MMIO; 0x10001000 -> not; 0x0FFFFFFF -> not. Flush between MEM and WB -> no mmio_store.
- Trap ordering:
  - trap_valid (cause 0x8000000000000007) in the same cycle as a retire -> that record has interrupt=0; next retire carries interrupt=1, cause=0x8000000000000007.
  - Second trap before any retire -> trap_overrun=1 and the later cause is reported.
- Counters: 10 retires -> retire_count=10. Then no retire for 4096 cycles -> hang=1 and it stays set; rstn low for one cycle -> all outputs return to 0.
